// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multicycle main controller (master) and the datapath (slave).
interface multicycle_ctrl_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemToReg;
  logic       RegDst;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] PCSrc;
  logic       instr_done;
  logic       illegal_op;
  logic       mem_err;
  logic [3:0] state_o;

  modport master (
    input  opcode, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg,
           RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc, instr_done,
           illegal_op, mem_err, state_o
  );

  modport slave (
    output opcode, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg,
           RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc, instr_done,
           illegal_op, mem_err, state_o
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS-subset main controller: sequences fetch/decode/execute/mem/writeback,
// with a ready handshake on memory steps and a watchdog that traps stalled accesses.
module multicycle_ctrl #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  multicycle_ctrl_if.master  bus
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_ILLEGAL = 4'd11,
    S_MEMERR  = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic             WDOG_EN  = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic               illegal_q, illegal_d;
  logic               mem_err_q, mem_err_d;
  logic               mem_wait;

  // State, watchdog counter and sticky error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= '0;
      illegal_q  <= 1'b0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      illegal_q  <= illegal_d;
      mem_err_q  <= mem_err_d;
    end
  end

  // Next-state sequencing; the watchdog trap overrides only a stalled memory step
  always_comb begin
    state_d  = state_q;
    mem_wait = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_wait = 1'b1;
        if (bus.mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        case (bus.opcode)
          OP_RTYPE:     state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          default:      state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: state_d = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        mem_wait = 1'b1;
        if (bus.mem_ready) state_d = S_MEMWB;
      end
      S_MEMWR: begin
        mem_wait = 1'b1;
        if (bus.mem_ready) state_d = S_FETCH;
      end
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB: state_d = S_FETCH;
      S_ILLEGAL, S_MEMERR: state_d = state_q;
      default:  state_d = S_FETCH;
    endcase
    if (WDOG_EN && mem_wait && !bus.mem_ready && (wait_cnt_q == CNT_LAST)) begin
      state_d = S_MEMERR;
    end
  end

  // Saturating stall counter, cleared on any state change; flags latch on entry to the trap states
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_d != state_q) begin
      wait_cnt_d = '0;
    end else if (mem_wait && !bus.mem_ready && (wait_cnt_q != CNT_MAX)) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
    illegal_d = illegal_q | (state_d == S_ILLEGAL);
    mem_err_d = mem_err_q | (state_d == S_MEMERR);
  end

  // Datapath controls decoded from the current state; FETCH request is masked during reset
  always_comb begin
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.IorD        = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.MemToReg    = 1'b0;
    bus.RegDst      = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.ALUSrcB     = 2'b00;
    bus.ALUOp       = 2'b00;
    bus.PCSrc       = 2'b00;
    bus.instr_done  = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.MemRead = rst_n;
        bus.IRWrite = rst_n & bus.mem_ready;
        bus.PCWrite = rst_n & bus.mem_ready;
        bus.ALUSrcB = 2'b01;
      end
      S_DECODE: bus.ALUSrcB = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        bus.IorD    = 1'b1;
        bus.MemRead = 1'b1;
      end
      S_MEMWB: begin
        bus.MemToReg   = 1'b1;
        bus.RegWrite   = 1'b1;
        bus.instr_done = 1'b1;
      end
      S_MEMWR: begin
        bus.IorD       = 1'b1;
        bus.MemWrite   = 1'b1;
        bus.instr_done = bus.mem_ready;
      end
      S_EXEC: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUOp   = 2'b10;
      end
      S_ALUWB: begin
        bus.RegDst     = 1'b1;
        bus.RegWrite   = 1'b1;
        bus.instr_done = 1'b1;
      end
      S_BRANCH: begin
        bus.ALUSrcA     = 1'b1;
        bus.ALUOp       = 2'b01;
        bus.PCWriteCond = 1'b1;
        bus.PCSrc       = 2'b01;
        bus.instr_done  = 1'b1;
      end
      S_ADDIWB: begin
        bus.RegWrite   = 1'b1;
        bus.instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.state_o    = state_q;
  assign bus.illegal_op = illegal_q;
  assign bus.mem_err    = mem_err_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: builds each instruction's expected state trace from its opcode
// and planned memory stalls, then compares state and every control output cycle by cycle.
module tb_multicycle_ctrl;
  localparam int unsigned TO = 4;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  int   exp_st[$];
  logic exp_rdy[$];

  always #5 clk = ~clk;

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(.TIMEOUT(TO), .CNT_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Packing order shared by observed and expected control vectors
  function automatic logic [18:0] obs_vec();
    return {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite,
            bus.MemToReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp,
            bus.PCSrc, bus.instr_done, bus.illegal_op, bus.mem_err};
  endfunction

  // Control table of each step, as the controller is documented
  function automatic logic [18:0] exp_vec(input int st, input logic rdy, input logic rst);
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, done, ill, merr;
    logic [1:0] asb, aop, pcs;
    {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, done, ill, merr} = '0;
    asb = 2'b00; aop = 2'b00; pcs = 2'b00;
    case (st)
      0:  begin mrd = 1'b1; asb = 2'b01; irw = rdy; pcw = rdy; end
      1:  asb = 2'b11;
      2:  begin asa = 1'b1; asb = 2'b10; end
      3:  begin iord = 1'b1; mrd = 1'b1; end
      4:  begin m2r = 1'b1; rw = 1'b1; done = 1'b1; end
      5:  begin iord = 1'b1; mwr = 1'b1; done = rdy; end
      6:  begin asa = 1'b1; aop = 2'b10; end
      7:  begin rdst = 1'b1; rw = 1'b1; done = 1'b1; end
      8:  begin asa = 1'b1; aop = 2'b01; pcwc = 1'b1; pcs = 2'b01; done = 1'b1; end
      9:  begin asa = 1'b1; asb = 2'b10; end
      10: begin rw = 1'b1; done = 1'b1; end
      11: ill = 1'b1;
      12: merr = 1'b1;
      default: ;
    endcase
    if (!rst) begin
      pcw = 1'b0; irw = 1'b0; mrd = 1'b0;
    end
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, pcs, done, ill, merr};
  endfunction

  // One clock: drive mem_ready, check on the falling edge, return just after the rising edge
  task automatic cyc(input int st, input logic rdy, input string tag);
    bus.mem_ready = rdy;
    @(negedge clk);
    check($sformatf("%s_state", tag), 32'(bus.state_o), 32'(st));
    check($sformatf("%s_ctl_s%0d", tag, st), 32'(obs_vec()), 32'(exp_vec(st, rdy, 1'b1)));
    @(posedge clk); #1;
  endtask

  // A memory step stalled for d cycles; d >= TO ends in the error trap
  task automatic push_mem(input int st, input int d, output bit err);
    err = 1'b0;
    if (d >= int'(TO)) begin
      for (int i = 0; i < int'(TO); i++) begin exp_st.push_back(st); exp_rdy.push_back(1'b0); end
      for (int i = 0; i < 3; i++) begin exp_st.push_back(12); exp_rdy.push_back(1'($urandom_range(0, 1))); end
      err = 1'b1;
    end else begin
      for (int i = 0; i < d; i++) begin exp_st.push_back(st); exp_rdy.push_back(1'b0); end
      exp_st.push_back(st); exp_rdy.push_back(1'b1);
    end
  endtask

  task automatic push_step(input int st);
    exp_st.push_back(st);
    exp_rdy.push_back(1'($urandom_range(0, 1)));
  endtask

  task automatic do_reset(input string tag);
    bus.mem_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    check($sformatf("%s_rst_state", tag), 32'(bus.state_o), 32'd0);
    check($sformatf("%s_rst_ctl", tag), 32'(obs_vec()), 32'(exp_vec(0, 1'b1, 1'b0)));
    @(negedge clk);
    check($sformatf("%s_rst_hold", tag), 32'(obs_vec()), 32'(exp_vec(0, 1'b1, 1'b0)));
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Plan and run one instruction; returns err when the watchdog trapped it
  task automatic run_instr(input logic [5:0] op, input int df, input int dm, input string tag,
                           output bit err);
    exp_st.delete();
    exp_rdy.delete();
    push_mem(0, df, err);
    if (!err) begin
      push_step(1);
      case (op)
        OP_R:    begin push_step(6); push_step(7); end
        OP_LW:   begin push_step(2); push_mem(3, dm, err); if (!err) push_step(4); end
        OP_SW:   begin push_step(2); push_mem(5, dm, err); end
        OP_BEQ:  push_step(8);
        OP_ADDI: begin push_step(9); push_step(10); end
        default: for (int i = 0; i < 20; i++) push_step(11);
      endcase
    end
    bus.opcode = op;
    foreach (exp_st[i]) cyc(exp_st[i], exp_rdy[i], tag);
    if (err || !(op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI})) do_reset(tag);
  endtask

  initial begin
    bit err;
    logic [5:0] ops [5];
    ops[0] = OP_R; ops[1] = OP_LW; ops[2] = OP_SW; ops[3] = OP_BEQ; ops[4] = OP_ADDI;
    bus.opcode    = OP_R;
    bus.mem_ready = 1'b1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("reset_state", 32'(bus.state_o), 32'd0);
    check("reset_ctl", 32'(obs_vec()), 32'(exp_vec(0, 1'b1, 1'b0)));
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_instr(OP_R, 0, 0, "rtype", err);
    run_instr(OP_LW, 2, 2, "lw_stall", err);
    run_instr(OP_BEQ, 0, 0, "beq", err);
    run_instr(OP_SW, 0, 0, "sw", err);
    run_instr(OP_ADDI, 0, 0, "addi", err);
    run_instr(6'b111111, 0, 0, "illegal", err);
    run_instr(OP_LW, 0, int'(TO), "lw_timeout", err);
    run_instr(OP_LW, 0, int'(TO) - 1, "lw_ready_last", err);
    run_instr(OP_SW, int'(TO), 0, "fetch_timeout", err);

    for (int n = 0; n < 40; n++) begin
      run_instr(ops[$urandom_range(0, 4)], int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                $sformatf("rand%0d", n), err);
    end

    // Asynchronous reset while the R-type writeback is asserting RegWrite
    bus.opcode = OP_R;
    cyc(0, 1'b1, "async");
    cyc(1, 1'b1, "async");
    cyc(6, 1'b1, "async");
    bus.mem_ready = 1'b1;
    @(negedge clk);
    check("async_aluwb_regwrite", 32'(bus.RegWrite), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_regwrite_drop", 32'(bus.RegWrite), 32'd0);
    check("async_state", 32'(bus.state_o), 32'd0);
    check("async_ctl", 32'(obs_vec()), 32'(exp_vec(0, 1'b1, 1'b0)));
    @(posedge clk); #1;
    check("async_memread_held", 32'(bus.MemRead), 32'd0);
    check("async_state_held", 32'(bus.state_o), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_instr(OP_ADDI, 0, 0, "post_async", err);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
